// File: rtl/myproject_mul_arbiter.sv
// Round-robin share of one signed 32x16 multiplier; result 2 cycles after accept.
// Backpressure: output holds while dout_ready=0, S1 holds, req_ready drops once S1 is full.
module myproject_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 48
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*din1_WIDTH-1:0]    req_din1,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [dout_WIDTH-1:0]            dout,
  output logic [ID_W-1:0]                  dout_id
);

  typedef struct packed {
    logic [din0_WIDTH-1:0] a;
    logic [din1_WIDTH-1:0] b;
    logic [ID_W-1:0]       id;
  } s1_t;

  logic [ID_W-1:0]    last_id;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               s1_valid;
  s1_t                s1_q;
  logic               s1_adv;
  logic               s1_load;
  logic               accept;
  logic [din0_WIDTH-1:0] sel_a;
  logic [din1_WIDTH-1:0] sel_b;
  logic signed [dout_WIDTH-1:0] prod;

  // Search begins one past the last accepted requester, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_id) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  assign s1_adv    = s1_valid & (~dout_valid | dout_ready);
  assign s1_load   = ~s1_valid | s1_adv;
  assign req_ready = ap_rst ? '0 : (grant & {NUM_REQ{s1_load}});
  assign accept    = grant_any & s1_load & ~ap_rst;

  assign sel_a = req_din0[int'(grant_id)*din0_WIDTH +: din0_WIDTH];
  assign sel_b = req_din1[int'(grant_id)*din1_WIDTH +: din1_WIDTH];

  assign prod = dout_WIDTH'($signed(s1_q.a)) * dout_WIDTH'($signed(s1_q.b));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last_id  <= ID_W'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (accept) begin
        last_id  <= grant_id;
        s1_q     <= '{a: sel_a, b: sel_b, id: grant_id};
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // A load while the old result is consumed keeps dout_valid high with no bubble.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_id    <= '0;
    end else begin
      if (s1_adv) begin
        dout       <= prod;
        dout_id    <= s1_q.id;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
// Directed vectors plus scoreboard soak for myproject_mul_arbiter.
module tb_myproject_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_din0;
  logic [63:0] req_din1;
  logic        dout_valid;
  logic        dout_ready;
  logic [47:0] dout;
  logic [1:0]  dout_id;

  int checks = 0;
  int errors = 0;

  myproject_mul_arbiter dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .dout_id(dout_id)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] p;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [15:0] b;
    logic [47:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] mulx(input logic [31:0] a, input logic [15:0] b);
    logic signed [47:0] sa, sb;
    sa = {{16{a[31]}}, a};
    sb = {{32{b[15]}}, b};
    return sa * sb;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [15:0] b);
    req_din0[i*32 +: 32] = a;
    req_din1[i*16 +: 16] = b;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] rand_b();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: begin r = $urandom; return r[15:0]; end
    endcase
  endfunction

  // Scoreboard: outputs popped before this cycle's accepts are pushed.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      sbq.delete();
    end else begin
      chk("ready_onehot0", {63'd0, $onehot0(req_ready)}, 64'd1);
      if (dout_valid && dout_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_dout", {16'd0, dout}, {16'd0, e.p});
          chk("sb_id", {62'd0, dout_id}, {62'd0, e.id});
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = 2'(i);
          e.p  = mulx(req_din0[i*32 +: 32], req_din1[i*16 +: 16]);
          sbq.push_back(e);
        end
      end
    end
  end

  initial begin
    vec_t vt[7];
    logic [3:0] sp_exp[7];
    logic [3:0] acc;
    int cnt;

    vt[0] = '{2, 32'h7FFF_FFFF, 16'h7FFF, 48'h3FFF_7FFF_8001};
    vt[1] = '{1, 32'h8000_0000, 16'h8000, 48'h4000_0000_0000};
    vt[2] = '{3, 32'hFFFF_FFFD, 16'h0005, 48'hFFFF_FFFF_FFF1};
    vt[3] = '{0, 32'h1234_5678, 16'h0010, 48'h0001_2345_6780};
    vt[4] = '{1, 32'h8000_0000, 16'h7FFF, 48'hC000_8000_0000};
    vt[5] = '{2, 32'h0000_0001, 16'hFFFF, 48'hFFFF_FFFF_FFFF};
    vt[6] = '{0, 32'h0000_0000, 16'h1234, 48'h0000_0000_0000};

    sp_exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b1000};

    ap_rst = 1'b1; req_valid = 4'h0; req_din0 = '0; req_din1 = '0; dout_ready = 1'b1;
    #1 req_valid = 4'hF;
    #1;
    chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_dout", {16'd0, dout}, 64'd0);
    chk("rst_dout_id", {62'd0, dout_id}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    req_valid = 4'h0;
    tick();
    tick();
    ap_rst = 1'b0;

    // Arithmetic / latency table
    for (int n = 0; n < 7; n++) begin
      set_op(vt[n].id, vt[n].a, vt[n].b);
      req_valid = 4'(1 << vt[n].id);
      #1 chk("vec_ready", {60'd0, req_ready}, 64'(1 << vt[n].id));
      tick();
      req_valid = 4'h0;
      chk("vec_lat1_valid", {63'd0, dout_valid}, 64'd0);
      tick();
      chk("vec_valid", {63'd0, dout_valid}, 64'd1);
      chk("vec_dout", {16'd0, dout}, {16'd0, vt[n].exp});
      chk("vec_id", {62'd0, dout_id}, 64'(vt[n].id));
      tick();
    end

    // Reset with two operations in flight
    for (int i = 0; i < 4; i++) set_op(i, 32'(i * 1000 - 1500), 16'(i * 7 + 3));
    req_valid = 4'hF;
    tick();
    tick();
    #1 ap_rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, dout_valid}, 64'd0);
    chk("midrst_ready", {60'd0, req_ready}, 64'd0);
    req_valid = 4'h0;
    tick();
    tick();
    ap_rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("no_stale", {63'd0, dout_valid}, 64'd0);
    end

    // Round-robin fairness from reset
    req_valid = 4'hF;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("rr_grant", {60'd0, req_ready}, 64'(1 << (n % 4)));
      if (n >= 2) begin
        chk("rr_valid", {63'd0, dout_valid}, 64'd1);
        chk("rr_id", {62'd0, dout_id}, 64'((n - 2) % 4));
      end
      tick();
    end

    // Backpressure from an empty pipeline; pointer is at 3
    req_valid = 4'h0;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) set_op(i, 32'hF000_0000 + 32'(i), 16'h0100 + 16'(i));
    dout_ready = 1'b0;
    req_valid  = 4'hF;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready != 4'h0) cnt++;
      if (c >= 2) begin
        chk("bp_valid", {63'd0, dout_valid}, 64'd1);
        chk("bp_ready", {60'd0, req_ready}, 64'd0);
        chk("bp_dout", {16'd0, dout}, {16'd0, mulx(32'hF000_0000, 16'h0100)});
        chk("bp_id", {62'd0, dout_id}, 64'd0);
      end
      tick();
    end
    chk("bp_accepts", 64'(cnt), 64'd2);
    dout_ready = 1'b1;
    req_valid  = 4'h0;
    tick();
    chk("bp_rel_valid", {63'd0, dout_valid}, 64'd1);
    chk("bp_rel_id", {62'd0, dout_id}, 64'd1);
    tick(); tick();
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    // Sparse wrap from reset pointer
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    req_valid = 4'b1001;
    for (int n = 0; n < 7; n++) begin
      if (n == 4) req_valid = 4'b1000;
      #1 chk("sparse_grant", {60'd0, req_ready}, {60'd0, sp_exp[n]});
      tick();
    end
    req_valid = 4'h0;
    tick(); tick(); tick();

    // Random soak honouring the hold-until-ready rule
    acc = 4'h0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, rand_a(), rand_b());
        end
      end
      dout_ready = ($urandom_range(0, 3) != 0);
      #1 acc = req_valid & req_ready;
      tick();
    end
    req_valid  = 4'h0;
    dout_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("soak_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/myproject_mul_arbiter.md
# myproject_mul_arbiter

Round-robin arbiter and two-stage pipeline that shares one signed 32x16 -> 48 multiplier among `NUM_REQ` requesters. Each requester presents signed operands under a valid/ready handshake. The block grants one requester per cycle, registers its operands, multiplies, and returns the full-width product tagged with the requester index. It sits between the kernel's parallel dot-product lanes and a single multiplier instance, trading throughput for DSP count.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester index; must equal ceil(log2(`NUM_REQ`)).
- `din0_WIDTH`, 32: operand A width, signed.
- `din1_WIDTH`, 16: operand B width, signed.
- `dout_WIDTH`, 48: product width; must equal `din0_WIDTH` + `din1_WIDTH`.

Ports:
- `ap_clk`  in  1  clock; all state on the rising edge.
- `ap_rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `NUM_REQ`  bit i: requester i presents operands.
- `req_ready`  out  `NUM_REQ`  bit i: requester i's operands are accepted this cycle; one-hot or zero.
- `req_din0`  in  `NUM_REQ`*`din0_WIDTH`  operand A; requester i occupies slice [i*32 +: 32].
- `req_din1`  in  `NUM_REQ`*`din1_WIDTH`  operand B; requester i occupies slice [i*16 +: 16].
- `dout_valid`  out  1  result available.
- `dout_ready`  in  1  consumer accepts the result.
- `dout`  out  `dout_WIDTH`  signed product.
- `dout_id`  out  `ID_W`  index of the requester that produced `dout`.

## Operation
- **Arbitration:** a combinational round-robin grant over `req_valid`.
  - The search starts at `last_id`+1 mod `NUM_REQ`.
  - `last_id` resets to `NUM_REQ`-1, so requester 0 has first priority after reset.
- **Pointer update:** `last_id` updates only on an accepted handshake (`req_valid[i]` & `req_ready[i]`). A grant that is not accepted does not move the pointer.
- **Ready:** `req_ready[i]` = grant[i] & `s1_load`.
  - `s1_load` = !`s1_valid` | `s1_adv`.
  - `s1_adv` = `s1_valid` & (!`dout_valid` | `dout_ready`).
- **Stage 1 (S1):** on acceptance, S1 loads `s1_a`, `s1_b`, `s1_id` and sets `s1_valid`=1. If S1 advances with no new acceptance, `s1_valid` clears.
- **Stage 2 (output):** when `s1_adv` is true, the output loads `dout` = `$signed(s1_a)*$signed(s1_b)`, `dout_id` = `s1_id`, and `dout_valid`=1.
  - If the output is consumed (`dout_ready` & `dout_valid`) and S1 does not advance, `dout_valid` clears.
- **Arithmetic:** full 48-bit signed product, with no truncation or saturation. The extreme case (-2^31)*(-2^15) = 2^46 fits.
- **Requester rules:** a requester must hold `req_valid` and its operands stable until ready. The block does not depend on this for correctness of other ports.
- **Ordering:** results emerge in acceptance order. No reordering and no drops.
- **Throughput:** one accepted operation per cycle when `dout_ready`=1 continuously.

## Timing
- **Reset values** (asynchronous, applied immediately on `ap_rst`):
  - `dout_valid`=0, `dout`=0, `dout_id`=0.
  - `s1_valid`=0, `last_id`=`NUM_REQ`-1.
  - `req_ready` forced to 0 while `ap_rst`=1.
- **Latency:** operands accepted at edge k appear on `dout` with `dout_valid`=1 in the cycle following edge k+1, i.e. 2 cycles, provided there is no backpressure.
- **Backpressure:** while `dout_valid`=1 & `dout_ready`=0:
  - `dout` and `dout_id` hold.
  - S1 holds if valid.
  - `req_ready` is 0 if S1 is full, so at most 2 operations are in flight.
  - Releasing `dout_ready` resumes full rate on the next edge, with no bubble.
- **Simultaneous consume and load:** output consumed and S1 advancing in the same edge → output reloads and `dout_valid` stays 1.
- **Idle:** all `req_valid`=0 → `req_ready`=0 and the pipeline drains. `last_id` is unchanged.
- **Single requester:** grant is retained every cycle, giving back-to-back accepts.
- **Reset mid-operation:** in-flight operations are discarded with no output. After deassertion, the first grant goes to the lowest-index valid requester.
- **Wrap-around:** pointer at `NUM_REQ`-1 with requester 0 valid → requester 0 is granted.

## Test plan
- **Reset:** assert `ap_rst` mid-stream with 2 operations in flight → `dout_valid` drops immediately and no stale result follows. With `req_valid`=1111 after release, the first accept goes to id 0.
- **Latency/arithmetic:** requester 2 sends A=0x7FFFFFFF, B=0x7FFF → two cycles later `dout`=0x3FFF7FFF8001, `dout_id`=2. A=0x80000000, B=0x8000 → `dout`=0x400000000000. A=-3, B=5 → `dout`=0xFFFFFFFFFFF1.
- **Round-robin fairness:** all 4 requesters valid continuously with `dout_ready`=1 → accepts are 0,1,2,3,0,... one per cycle, and `dout_id` follows the same order.
- **Backpressure:** hold `dout_ready`=0 for 5 cycles during a stream → exactly 2 operations accepted, `dout` stable, `req_ready`=0. On release, results arrive in order with no loss or duplication.
- **Sparse wrap:** `req_valid`=1001 with the pointer at 3 → grant 0, then 3, then 0. Drop `req_valid[0]` → only 3 is granted repeatedly.
- **Random soak:** random valid, operands, and `dout_ready` over 10k cycles against a scoreboard → every product exact, tagged correctly, and in order.
